// File: rtl/sram_bridge_pkg.sv
// sram_bridge shared types.
// Channel state and owner encodings used by the bridge and its channels.
package sram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_DONE  = 3'd5
    } chan_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam int CNT_W = 3;

    // True when port p owns a channel that is finishing its access.
    function automatic logic owns_done(chan_state_t s, owner_t o, owner_t p);
        return ((s == ST_DONE) || (s == ST_HOLD)) && (o == p);
    endfunction

endpackage

// File: rtl/sram_bridge_if.sv
// CPU-side SRAM-style port bundle for sram_bridge.
// master = CPU, slave = bridge.
interface sram_bridge_if;

    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        inst_stall;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        data_stall;

    modport master (
        output inst_sram_en, inst_sram_addr,
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  inst_sram_rdata, inst_stall,
        input  data_sram_rdata, data_stall
    );

    modport slave (
        input  inst_sram_en, inst_sram_addr,
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output inst_sram_rdata, inst_stall,
        output data_sram_rdata, data_stall
    );

endinterface

// File: rtl/sram_bridge_chan_ctrl.sv
// One async-SRAM access channel: arbiter, wait counter, FSM, pin registers.
// Reads: IDLE-READ(W+1)-DONE. Writes: IDLE-SETUP-PULSE(W+1)-HOLD.
module sram_chan_ctrl
    import sram_bridge_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int RAM_AW      = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_inst,
    input  logic              req_data,
    input  logic [RAM_AW-1:0] inst_addr,
    input  logic [RAM_AW-1:0] data_addr,
    input  logic [3:0]        data_wen,
    input  logic [31:0]       data_wdata,
    output owner_t            owner,
    output logic              done_inst,
    output logic              done_data,
    output logic              rd_capture,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_be_n,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic [31:0]       ram_wdata,
    output logic              ram_data_oe
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    chan_state_t       state;
    owner_t            last_owner;
    logic [CNT_W-1:0]  cnt;

    owner_t            grant;
    logic              grant_any;
    logic [RAM_AW-1:0] grant_addr;
    logic [3:0]        grant_wen;

    // Round-robin pick between the two ports; the instruction port only reads.
    always_comb begin
        grant_any = req_inst | req_data;
        grant     = OWN_DATA;
        if (req_inst && req_data) begin
            grant = (last_owner == OWN_DATA) ? OWN_INST : OWN_DATA;
        end else if (req_inst) begin
            grant = OWN_INST;
        end
        grant_addr = (grant == OWN_INST) ? inst_addr : data_addr;
        grant_wen  = (grant == OWN_INST) ? 4'b0000 : data_wen;
    end

    assign done_inst  = owns_done(state, owner, OWN_INST);
    assign done_data  = owns_done(state, owner, OWN_DATA);
    assign rd_capture = (state == ST_READ) && (cnt == '0);

    // Access sequencer with registered RAM pin outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            owner       <= OWN_INST;
            last_owner  <= OWN_DATA;
            cnt         <= '0;
            ram_addr    <= '0;
            ram_be_n    <= 4'b1111;
            ram_ce_n    <= 1'b1;
            ram_oe_n    <= 1'b1;
            ram_we_n    <= 1'b1;
            ram_wdata   <= '0;
            ram_data_oe <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner      <= grant;
                        last_owner <= grant;
                        ram_addr   <= grant_addr;
                        ram_ce_n   <= 1'b0;
                        cnt        <= WAIT_LOAD;
                        if (grant_wen != 4'b0000) begin
                            state       <= ST_SETUP;
                            ram_be_n    <= ~grant_wen;
                            ram_wdata   <= data_wdata;
                            ram_data_oe <= 1'b1;
                        end else begin
                            state    <= ST_READ;
                            ram_oe_n <= 1'b0;
                            ram_be_n <= 4'b0000;
                        end
                    end
                end
                ST_READ: begin
                    if (cnt == '0) begin
                        state    <= ST_DONE;
                        ram_ce_n <= 1'b1;
                        ram_oe_n <= 1'b1;
                        ram_be_n <= 4'b1111;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_SETUP: begin
                    state    <= ST_PULSE;
                    ram_we_n <= 1'b0;
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        state    <= ST_HOLD;
                        ram_we_n <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_HOLD: begin
                    state       <= ST_IDLE;
                    ram_ce_n    <= 1'b1;
                    ram_be_n    <= 4'b1111;
                    ram_data_oe <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_bridge.sv
// CPU inst/data ports to BaseRAM/ExtRAM bridge.
// Target decode, stall combine and per-port read-data registers.
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int EXT_SEL_BIT = 22,
    parameter int RAM_AW      = 20
) (
    input  logic              clk,
    input  logic              resetn,
    sram_bridge_if.slave      bus,
    output logic [RAM_AW-1:0] base_ram_addr,
    output logic [3:0]        base_ram_be_n,
    output logic              base_ram_ce_n,
    output logic              base_ram_oe_n,
    output logic              base_ram_we_n,
    output logic [31:0]       base_ram_wdata,
    input  logic [31:0]       base_ram_rdata,
    output logic              base_ram_data_oe,
    output logic [RAM_AW-1:0] ext_ram_addr,
    output logic [3:0]        ext_ram_be_n,
    output logic              ext_ram_ce_n,
    output logic              ext_ram_oe_n,
    output logic              ext_ram_we_n,
    output logic [31:0]       ext_ram_wdata,
    input  logic [31:0]       ext_ram_rdata,
    output logic              ext_ram_data_oe
);

    logic              inst_to_ext;
    logic              data_to_ext;
    logic [RAM_AW-1:0] inst_word;
    logic [RAM_AW-1:0] data_word;

    logic   base_req_inst, base_req_data;
    logic   ext_req_inst, ext_req_data;
    owner_t base_owner, ext_owner;
    logic   base_done_inst, base_done_data, base_cap;
    logic   ext_done_inst, ext_done_data, ext_cap;

    logic [31:0] inst_rdata;
    logic [31:0] data_rdata;

    // Only the word-address and select bits matter; the rest is decoded upstream.
    logic unused_addr;
    assign unused_addr = ^{bus.inst_sram_addr, bus.data_sram_addr};

    assign inst_to_ext = bus.inst_sram_addr[EXT_SEL_BIT];
    assign data_to_ext = bus.data_sram_addr[EXT_SEL_BIT];
    assign inst_word   = bus.inst_sram_addr[RAM_AW+1:2];
    assign data_word   = bus.data_sram_addr[RAM_AW+1:2];

    assign base_req_inst = bus.inst_sram_en & ~inst_to_ext;
    assign base_req_data = bus.data_sram_en & ~data_to_ext;
    assign ext_req_inst  = bus.inst_sram_en & inst_to_ext;
    assign ext_req_data  = bus.data_sram_en & data_to_ext;

    sram_chan_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .RAM_AW      (RAM_AW)
    ) u_base (
        .clk         (clk),
        .resetn      (resetn),
        .req_inst    (base_req_inst),
        .req_data    (base_req_data),
        .inst_addr   (inst_word),
        .data_addr   (data_word),
        .data_wen    (bus.data_sram_wen),
        .data_wdata  (bus.data_sram_wdata),
        .owner       (base_owner),
        .done_inst   (base_done_inst),
        .done_data   (base_done_data),
        .rd_capture  (base_cap),
        .ram_addr    (base_ram_addr),
        .ram_be_n    (base_ram_be_n),
        .ram_ce_n    (base_ram_ce_n),
        .ram_oe_n    (base_ram_oe_n),
        .ram_we_n    (base_ram_we_n),
        .ram_wdata   (base_ram_wdata),
        .ram_data_oe (base_ram_data_oe)
    );

    sram_chan_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .RAM_AW      (RAM_AW)
    ) u_ext (
        .clk         (clk),
        .resetn      (resetn),
        .req_inst    (ext_req_inst),
        .req_data    (ext_req_data),
        .inst_addr   (inst_word),
        .data_addr   (data_word),
        .data_wen    (bus.data_sram_wen),
        .data_wdata  (bus.data_sram_wdata),
        .owner       (ext_owner),
        .done_inst   (ext_done_inst),
        .done_data   (ext_done_data),
        .rd_capture  (ext_cap),
        .ram_addr    (ext_ram_addr),
        .ram_be_n    (ext_ram_be_n),
        .ram_ce_n    (ext_ram_ce_n),
        .ram_oe_n    (ext_ram_oe_n),
        .ram_we_n    (ext_ram_we_n),
        .ram_wdata   (ext_ram_wdata),
        .ram_data_oe (ext_ram_data_oe)
    );

    assign bus.inst_stall = bus.inst_sram_en & ~(base_done_inst | ext_done_inst);
    assign bus.data_stall = bus.data_sram_en & ~(base_done_data | ext_done_data);

    assign bus.inst_sram_rdata = inst_rdata;
    assign bus.data_sram_rdata = data_rdata;

    // Capture read data on the last READ edge of whichever channel serves the port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            if (base_cap && (base_owner == OWN_INST)) begin
                inst_rdata <= base_ram_rdata;
            end else if (ext_cap && (ext_owner == OWN_INST)) begin
                inst_rdata <= ext_ram_rdata;
            end
            if (base_cap && (base_owner == OWN_DATA)) begin
                data_rdata <= base_ram_rdata;
            end else if (ext_cap && (ext_owner == OWN_DATA)) begin
                data_rdata <= ext_ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge with W=1.
// Small word-addressed RAM models sit on both pin sets.
module tb_sram_bridge;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sram_bridge_if bus();

    logic [19:0] base_ram_addr;
    logic [3:0]  base_ram_be_n;
    logic        base_ram_ce_n;
    logic        base_ram_oe_n;
    logic        base_ram_we_n;
    logic [31:0] base_ram_wdata;
    logic [31:0] base_ram_rdata;
    logic        base_ram_data_oe;
    logic [19:0] ext_ram_addr;
    logic [3:0]  ext_ram_be_n;
    logic        ext_ram_ce_n;
    logic        ext_ram_oe_n;
    logic        ext_ram_we_n;
    logic [31:0] ext_ram_wdata;
    logic [31:0] ext_ram_rdata;
    logic        ext_ram_data_oe;

    sram_bridge #(
        .WAIT_CYCLES (1),
        .EXT_SEL_BIT (22),
        .RAM_AW      (20)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .bus              (bus),
        .base_ram_addr    (base_ram_addr),
        .base_ram_be_n    (base_ram_be_n),
        .base_ram_ce_n    (base_ram_ce_n),
        .base_ram_oe_n    (base_ram_oe_n),
        .base_ram_we_n    (base_ram_we_n),
        .base_ram_wdata   (base_ram_wdata),
        .base_ram_rdata   (base_ram_rdata),
        .base_ram_data_oe (base_ram_data_oe),
        .ext_ram_addr     (ext_ram_addr),
        .ext_ram_be_n     (ext_ram_be_n),
        .ext_ram_ce_n     (ext_ram_ce_n),
        .ext_ram_oe_n     (ext_ram_oe_n),
        .ext_ram_we_n     (ext_ram_we_n),
        .ext_ram_wdata    (ext_ram_wdata),
        .ext_ram_rdata    (ext_ram_rdata),
        .ext_ram_data_oe  (ext_ram_data_oe)
    );

    logic [31:0] base_mem [64];
    logic [31:0] ext_mem [64];
    logic mem_ready = 1'b0;

    logic unused_tb;
    assign unused_tb = ^{base_ram_addr[19:6], ext_ram_addr[19:6], ext_ram_oe_n};

    assign base_ram_rdata = base_mem[base_ram_addr[5:0]];
    assign ext_ram_rdata  = ext_mem[ext_ram_addr[5:0]];

    // Preload once, then write bytes while ce_n and we_n are low.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) begin
                base_mem[i] <= 32'h0;
                ext_mem[i]  <= 32'h0;
            end
            base_mem[0] <= 32'hCAFE_0001;
            base_mem[1] <= 32'h1111_1111;
            base_mem[2] <= 32'h2222_2222;
            base_mem[4] <= 32'h1234_5678;
            ext_mem[0]  <= 32'hBEEF_0002;
            mem_ready   <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (!base_ram_ce_n && !base_ram_we_n && !base_ram_be_n[b])
                    base_mem[base_ram_addr[5:0]][8*b +: 8] <= base_ram_wdata[8*b +: 8];
                if (!ext_ram_ce_n && !ext_ram_we_n && !ext_ram_be_n[b])
                    ext_mem[ext_ram_addr[5:0]][8*b +: 8] <= ext_ram_wdata[8*b +: 8];
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    logic [3:0]  st, st2, oe;
    logic [4:0]  ds, wn;
    logic [5:0]  doe;
    logic [19:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd1;
    int done_who [4];
    int done_cyc [4];
    int n_done;
    int done_at;

    initial begin
        bus.inst_sram_en    = 1'b0;
        bus.inst_sram_addr  = 32'h0;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'h0;
        bus.data_sram_addr  = 32'h0;
        bus.data_sram_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ce_n", 32'(base_ram_ce_n), 32'd1);
        check("rst_oe_n", 32'(base_ram_oe_n), 32'd1);
        check("rst_we_n", 32'(ext_ram_we_n), 32'd1);
        check("rst_be_n", 32'(base_ram_be_n), 32'hF);
        check("rst_addr", 32'(ext_ram_addr), 32'd0);
        check("rst_wdata", base_ram_wdata, 32'd0);
        check("rst_data_oe", 32'(ext_ram_data_oe), 32'd0);
        check("rst_inst_rdata", bus.inst_sram_rdata, 32'd0);
        check("rst_stall_follows_en", 32'(bus.data_stall), 32'd1);
        bus.data_sram_en = 1'b0;
        resetn = 1'b1;

        // Instruction read from BaseRAM word 4
        @(posedge clk); #1;
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = 32'h8000_0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            st[k] = bus.inst_stall;
            oe[k] = base_ram_oe_n;
            if (k == 1) a1 = base_ram_addr;
        end
        check("rd_inst_stall_seq", 32'(st), 32'h7);
        check("rd_oe_n_seq", 32'(oe), 32'h9);
        check("rd_base_addr", 32'(a1), 32'd4);
        check("rd_inst_rdata", bus.inst_sram_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        bus.inst_sram_en = 1'b0;

        // Data partial write to ExtRAM word 2
        bus.data_sram_en    = 1'b1;
        bus.data_sram_addr  = 32'h8040_0008;
        bus.data_sram_wen   = 4'b0011;
        bus.data_sram_wdata = 32'hAABB_CCDD;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ds[k]  = bus.data_stall;
            wn[k]  = ext_ram_we_n;
            doe[k] = ext_ram_data_oe;
            if (k == 1) begin
                a1  = ext_ram_addr;
                be1 = ext_ram_be_n;
                wd1 = ext_ram_wdata;
            end
        end
        @(posedge clk); #1;
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'b0000;
        @(negedge clk);
        doe[5] = ext_ram_data_oe;
        check("wr_data_stall_seq", 32'(ds), 32'h0F);
        check("wr_we_n_seq", 32'(wn), 32'h13);
        check("wr_data_oe_seq", 32'(doe), 32'h1E);
        check("wr_ext_addr", 32'(a1), 32'd2);
        check("wr_be_n", 32'(be1), 32'hC);
        check("wr_wdata", wd1, 32'hAABB_CCDD);
        check("wr_ext_mem", ext_mem[2], 32'h0000_CCDD);
        check("wr_inst_rdata_held", bus.inst_sram_rdata, 32'h1234_5678);

        // Concurrent reads on different RAMs
        @(posedge clk); #1;
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = 32'h8000_0000;
        bus.data_sram_en   = 1'b1;
        bus.data_sram_addr = 32'h8040_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            st[k]  = bus.inst_stall;
            st2[k] = bus.data_stall;
        end
        check("par_inst_stall_seq", 32'(st), 32'h7);
        check("par_data_stall_seq", 32'(st2), 32'h7);
        check("par_inst_rdata", bus.inst_sram_rdata, 32'hCAFE_0001);
        check("par_data_rdata", bus.data_sram_rdata, 32'hBEEF_0002);
        @(posedge clk); #1;
        bus.inst_sram_en = 1'b0;
        bus.data_sram_en = 1'b0;

        // Reset again so the first tie starts from last_owner = DATA
        resetn = 1'b0;
        #2;
        check("rst2_inst_rdata", bus.inst_sram_rdata, 32'd0);
        check("rst2_data_rdata", bus.data_sram_rdata, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Both ports read BaseRAM continuously
        @(posedge clk); #1;
        bus.inst_sram_en   = 1'b1;
        bus.inst_sram_addr = 32'h8000_0004;
        bus.data_sram_en   = 1'b1;
        bus.data_sram_addr = 32'h8000_0008;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            done_who[i] = -1;
            done_cyc[i] = -1;
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (!bus.inst_stall) begin
                check("rr_inst_rdata", bus.inst_sram_rdata, 32'h1111_1111);
                if (n_done < 4) begin
                    done_who[n_done] = 0;
                    done_cyc[n_done] = c;
                    n_done++;
                end
            end
            if (!bus.data_stall) begin
                check("rr_data_rdata", bus.data_sram_rdata, 32'h2222_2222);
                if (n_done < 4) begin
                    done_who[n_done] = 1;
                    done_cyc[n_done] = c;
                    n_done++;
                end
            end
        end
        check("rr_done_count", 32'(n_done), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_who_%0d", i), 32'(done_who[i]), 32'(i % 2));
            check($sformatf("rr_cyc_%0d", i), 32'(done_cyc[i]), 32'(4 * i + 3));
        end
        @(posedge clk); #1;
        bus.inst_sram_en = 1'b0;
        bus.data_sram_en = 1'b0;

        // Reset during the write pulse, then restart
        @(posedge clk); #1;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_addr  = 32'h8000_0020;
        bus.data_sram_wen   = 4'b1111;
        bus.data_sram_wdata = 32'h55AA_55AA;
        repeat (3) @(negedge clk);
        check("pulse_we_n_low", 32'(base_ram_we_n), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_we_n", 32'(base_ram_we_n), 32'd1);
        check("arst_ce_n", 32'(base_ram_ce_n), 32'd1);
        check("arst_data_oe", 32'(base_ram_data_oe), 32'd0);
        check("arst_data_stall", 32'(bus.data_stall), 32'd1);
        @(negedge clk);
        resetn = 1'b1;
        done_at = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!bus.data_stall) begin
                done_at = i;
                break;
            end
        end
        check("arst_restart_latency", 32'(done_at), 32'd4);
        @(posedge clk); #1;
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'b0000;
        @(negedge clk);
        check("arst_base_mem", base_mem[8], 32'h55AA_55AA);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
